// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: writeback wins, JAL $31 link writes queue and drain on idle cycles.
// Optional read bypass of pending link data is enabled by defining LINK_BYPASS_EN.
module regfile_write_arbiter #(
  parameter int DATA_W     = 32,
  parameter int LINK_DEPTH = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pipe_stall,
  input  logic                          wb_we,
  input  logic [4:0]                    wb_addr,
  input  logic [DATA_W-1:0]             wb_data,
  input  logic                          link_req,
  input  logic [DATA_W-1:0]             link_data,
  output logic                          link_ready,
  input  logic [4:0]                    rd_addr1,
  input  logic [4:0]                    rd_addr2,
  output logic                          byp_hit1,
  output logic                          byp_hit2,
  output logic [DATA_W-1:0]             byp_data,
  output logic                          rf_we,
  output logic [4:0]                    rf_addr,
  output logic [DATA_W-1:0]             rf_data,
  output logic [$clog2(LINK_DEPTH):0]   link_count,
  output logic                          stall_req
);

  localparam int PW = $clog2(LINK_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [4:0] LINK_REG = 5'd31;

  logic [DATA_W-1:0] q_data [LINK_DEPTH];
  logic [1:0]        q_age  [LINK_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [SW-1:0]     starve_cnt;

  logic          wb_issue, q_empty, deq, enq, supersede, stop;
  logic [CW-1:0] flush_n;
  logic [PW-1:0] idx;

  assign q_empty    = (link_count == '0);
  assign link_ready = (link_count != CW'(LINK_DEPTH));
  assign wb_issue   = wb_we && (wb_addr != 5'd0);
  assign deq        = !wb_issue && !q_empty;
  assign enq        = link_req && link_ready;
  assign supersede  = wb_issue && (wb_addr == LINK_REG);

  // Ages never increase toward the tail, so age-3 entries always form a prefix from the head.
  // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    flush_n = '0;
    stop    = 1'b0;
    idx     = '0;
    for (int i = 0; i < LINK_DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (!stop && supersede && (CW'(i) < link_count) && (q_age[idx] == 2'd3))
        flush_n = flush_n + CW'(1);
      else
        stop = 1'b1;
    end
  end

  // NOTE: queue storage is deliberately not reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LINK_DEPTH; i++) begin
      if (!pipe_stall && q_age[i] != 2'd3)
        q_age[i] <= q_age[i] + 2'd1;
    end
    if (enq) begin
      q_data[wr_ptr] <= link_data;
      q_age[wr_ptr]  <= 2'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      link_count <= '0;
      starve_cnt <= '0;
      rf_we      <= 1'b0;
      rf_addr    <= 5'd0;
      rf_data    <= '0;
    end else begin
      rd_ptr     <= rd_ptr + PW'(flush_n) + PW'(deq);
      wr_ptr     <= wr_ptr + PW'(enq);
      link_count <= link_count - flush_n - CW'(deq) + CW'(enq);

      if (q_empty || deq)
        starve_cnt <= '0;
      else if (wb_issue && starve_cnt != SW'(STARVE_MAX))
        starve_cnt <= starve_cnt + SW'(1);

      rf_we <= wb_issue || deq;
      if (wb_issue) begin
        rf_addr <= wb_addr;
        rf_data <= wb_data;
      end else if (deq) begin
        rf_addr <= LINK_REG;
        rf_data <= q_data[rd_ptr];
      end
    end
  end

`ifdef LINK_BYPASS_EN
  assign byp_hit1  = (rd_addr1 == LINK_REG) && !q_empty;
  assign byp_hit2  = (rd_addr2 == LINK_REG) && !q_empty;
  assign byp_data  = q_data[wr_ptr - PW'(1)];
  assign stall_req = !link_ready || (starve_cnt == SW'(STARVE_MAX));
`else
  // Without the bypass, ID reads of $31 hold off until every pending link write has drained.
  assign byp_hit1  = 1'b0;
  assign byp_hit2  = 1'b0;
  assign byp_data  = '0;
  assign stall_req = !link_ready || (starve_cnt == SW'(STARVE_MAX)) ||
                     (((rd_addr1 == LINK_REG) || (rd_addr2 == LINK_REG)) && !q_empty);
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, drain, fill, starvation, supersede, bypass.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_stall, wb_we, link_req, link_ready;
  logic [4:0]  wb_addr, rd_addr1, rd_addr2, rf_addr;
  logic [31:0] wb_data, link_data, byp_data, rf_data;
  logic        byp_hit1, byp_hit2, rf_we, stall_req;
  logic [1:0]  link_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk(clk), .rst(rst), .pipe_stall(pipe_stall),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .link_req(link_req), .link_data(link_data), .link_ready(link_ready),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2), .byp_data(byp_data),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .link_count(link_count), .stall_req(stall_req)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one posedge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    wb_we = we; wb_addr = a; wb_data = d;
  endtask

  task automatic set_link(input logic req, input logic [31:0] d);
    link_req = req; link_data = d;
  endtask

  initial begin
    rst = 1'b0; pipe_stall = 1'b0; rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    set_wb(1'b0, 5'd0, 32'h0);
    set_link(1'b0, 32'h0);
    #12;
    check("rst_rf_we", rf_we, 0);
    check("rst_rf_addr", rf_addr, 0);
    check("rst_rf_data", rf_data, 0);
    check("rst_byp_hit1", byp_hit1, 0);
    @(negedge clk) rst = 1'b1;

    // 1: idle after reset
    repeat (3) tick();
    check("t1_rf_we", rf_we, 0);
    check("t1_ready", link_ready, 1);
    check("t1_count", link_count, 0);
    check("t1_stall", stall_req, 0);

    // 2: single link write drains two cycles after request
    set_link(1'b1, 32'h0040_0010);
    tick();
    check("t2_count_enq", link_count, 1);
    check("t2_rf_we_early", rf_we, 0);
    set_link(1'b0, 32'h0);
    tick();
    check("t2_rf_we", rf_we, 1);
    check("t2_rf_addr", rf_addr, 31);
    check("t2_rf_data", rf_data, 32'h0040_0010);
    check("t2_count_drain", link_count, 0);

    // 3: fill under continuous writeback, third request ignored, then drain in order
    set_wb(1'b1, 5'd5, 32'h55);
    set_link(1'b1, 32'h10);
    tick();
    check("t3_count1", link_count, 1);
    check("t3_wb_addr", rf_addr, 5);
    check("t3_wb_data", rf_data, 32'h55);
    set_link(1'b1, 32'h20);
    tick();
    check("t3_count2", link_count, 2);
    check("t3_ready", link_ready, 0);
    check("t3_stall", stall_req, 1);
`ifdef LINK_BYPASS_EN
    check("t3_byp_youngest", byp_data, 32'h20);
`endif
    set_link(1'b1, 32'h30);
    tick();
    check("t3_full_ignored", link_count, 2);
    set_link(1'b0, 32'h0);
    set_wb(1'b0, 5'd0, 32'h0);
    tick();
    check("t3_drain1_addr", rf_addr, 31);
    check("t3_drain1_data", rf_data, 32'h10);
    check("t3_count_after1", link_count, 1);
    tick();
    check("t3_drain2_we", rf_we, 1);
    check("t3_drain2_data", rf_data, 32'h20);
    check("t3_count_after2", link_count, 0);
    tick();
    check("t3_idle_we", rf_we, 0);

    // 4: starvation stall after three blocked cycles, cleared by the dequeue
    set_wb(1'b1, 5'd5, 32'h66);
    set_link(1'b1, 32'h40);
    tick();
    set_link(1'b0, 32'h0);
    check("t4_stall0", stall_req, 0);
    tick();
    tick();
    check("t4_stall_cyc2", stall_req, 0);
    tick();
    check("t4_stall_cyc3", stall_req, 1);
    set_wb(1'b0, 5'd0, 32'h0);
    tick();
    check("t4_deq_data", rf_data, 32'h40);
    check("t4_stall_clear", stall_req, 0);

    // 5: age-3 entry superseded by a writeback to $31
    set_wb(1'b1, 5'd5, 32'h77);
    set_link(1'b1, 32'h30);
    tick();
    set_link(1'b0, 32'h0);
    repeat (3) tick();
    set_wb(1'b1, 5'd31, 32'h99);
    tick();
    check("t5_wb31_data", rf_data, 32'h99);
    check("t5_count", link_count, 0);
    set_wb(1'b0, 5'd0, 32'h0);
    tick();
    check("t5_no_link_write", rf_we, 0);
    check("t5_stall", stall_req, 0);

    // 5b: a young entry survives a $31 writeback
    set_link(1'b1, 32'h31);
    tick();
    set_link(1'b0, 32'h0);
    set_wb(1'b1, 5'd31, 32'h98);
    tick();
    check("t5b_survives", link_count, 1);
    set_wb(1'b0, 5'd0, 32'h0);
    tick();
    check("t5b_drain", rf_data, 32'h31);

    // 5c: pipe_stall freezes aging, so the entry is not superseded
    set_wb(1'b1, 5'd5, 32'h88);
    set_link(1'b1, 32'h50);
    tick();
    set_link(1'b0, 32'h0);
    pipe_stall = 1'b1;
    repeat (3) tick();
    set_wb(1'b1, 5'd31, 32'h97);
    tick();
    pipe_stall = 1'b0;
    check("t5c_kept", link_count, 1);
    set_wb(1'b0, 5'd0, 32'h0);
    tick();
    check("t5c_drain", rf_data, 32'h50);

    // 5d: writeback to $0 is not issued and lets the queue drain
    set_link(1'b1, 32'h60);
    tick();
    set_link(1'b0, 32'h0);
    set_wb(1'b1, 5'd0, 32'hDEAD);
    tick();
    check("t5d_zero_addr", rf_addr, 31);
    check("t5d_zero_data", rf_data, 32'h60);
    set_wb(1'b0, 5'd0, 32'h0);
    tick();

    // 6: read of $31 with one pending entry
    set_wb(1'b1, 5'd5, 32'h11);
    set_link(1'b1, 32'h44);
    tick();
    set_link(1'b0, 32'h0);
    rd_addr1 = 5'd31;
    #1;
`ifdef LINK_BYPASS_EN
    check("t6_hit1", byp_hit1, 1);
    check("t6_byp_data", byp_data, 32'h44);
    check("t6_stall", stall_req, 0);
`else
    check("t6_hit1", byp_hit1, 0);
    check("t6_byp_data", byp_data, 0);
    check("t6_stall", stall_req, 1);
`endif
    check("t6_hit2", byp_hit2, 0);
    set_wb(1'b0, 5'd0, 32'h0);
    tick();
    check("t6_drain", rf_data, 32'h44);
    check("t6_stall_after", stall_req, 0);
    check("t6_hit1_after", byp_hit1, 0);
    rd_addr1 = 5'd0;

    // Reset mid-operation discards pending link writes
    set_wb(1'b1, 5'd5, 32'h22);
    set_link(1'b1, 32'h70);
    tick();
    check("mr_pending", link_count, 1);
    set_link(1'b0, 32'h0);
    set_wb(1'b0, 5'd0, 32'h0);
    #2 rst = 1'b0;
    #1;
    check("mr_count", link_count, 0);
    check("mr_rf_we", rf_we, 0);
    @(negedge clk) rst = 1'b1;
    tick();
    check("mr_no_drain", rf_we, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
